fifo32_feeder: RTL and testbench



---
 rtl/fifo32_feeder.sv | 194 +++++++++++++++++++
 tb/tb_fifo32_feeder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo32_feeder.sv
// fifo32_feeder: clkLOW-domain producer for the 32-bit instruction FIFO.
// Streams a programmed run of words from a synchronous memory into the FIFO.
// It stalls on AFULL/FULL and holds after each BURST-word burst until
// RSTcount reports that the FIFO has drained.
// Optional build: define FEEDER_STATS_EN to add the stallCnt output.
module fifo32_feeder #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned BURST     = 16,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic              clkLOW,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [CNT_W-1:0]  wordCount,
    output logic              memRd,
    output logic [ADDR_W-1:0] memAddr,
    input  logic [31:0]       memData,
    input  logic              AFULL,
    input  logic              FULL,
    input  logic              RSTcount,
    output logic              validIN,
    output logic [31:0]       wrData,
    output logic              busy,
    output logic              done
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]       stallCnt
`endif
);

    localparam int unsigned        BW      = $clog2(BURST + 1);
    localparam logic [BW-1:0]      BURST_V = BW'(BURST);
    localparam logic [ADDR_W-1:0]  STEP_V  = ADDR_W'(ADDR_STEP);

    typedef enum logic [2:0] {StIdle, StFetch, StPause, StDrainWait, StFinish} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  count_q, issued_q, pushed_q, pushed_nx;
    logic [BW-1:0]     biss_q, bpush_q, bpush_nx;
    logic              out_v_q;
    logic [31:0]       out_d_q, skid0_q, skid1_q;
    logic [1:0]        skid_cnt_q;
    logic              rd_pend_q;
    logic              push, can_issue;

    // Push handshake, progress counters and read-issue qualification
    always_comb begin
        push      = out_v_q & ~FULL;
        pushed_nx = pushed_q + CNT_W'(push);
        bpush_nx  = bpush_q + BW'(push);
        can_issue = (state_q == StFetch) && !AFULL && !FULL && (skid_cnt_q == 2'd0) &&
                    (issued_q < count_q) && (biss_q < BURST_V);
    end

    // The FIFO never sees a write strobe while it reports FULL
    assign validIN = push;
    assign wrData  = out_d_q;

    // Control FSM with registered memory strobe, busy and done
    always_ff @(posedge clkLOW or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            pushed_q <= '0;
            biss_q   <= '0;
            bpush_q  <= '0;
            memRd    <= 1'b0;
            memAddr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            memRd <= 1'b0;
            done  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (wordCount != '0) begin
                            addr_q   <= baseAddr;
                            count_q  <= wordCount;
                            issued_q <= '0;
                            pushed_q <= '0;
                            biss_q   <= '0;
                            bpush_q  <= '0;
                            busy     <= 1'b1;
                            state_q  <= StFetch;
                        end else begin
                            done    <= 1'b1;
                            state_q <= StFinish;
                        end
                    end
                end
                StFetch, StPause: begin
                    if (can_issue) begin
                        memRd    <= 1'b1;
                        memAddr  <= addr_q;
                        addr_q   <= addr_q + STEP_V;
                        issued_q <= issued_q + CNT_W'(1);
                        biss_q   <= biss_q + BW'(1);
                    end
                    pushed_q <= pushed_nx;
                    bpush_q  <= bpush_nx;
                    // A full burst always waits for the drain, even if it is the last one
                    if (bpush_nx == BURST_V) begin
                        state_q <= StDrainWait;
                    end else if (pushed_nx == count_q) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StFinish;
                    end else if (AFULL || FULL) begin
                        state_q <= StPause;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                StDrainWait: begin
                    if (RSTcount) begin
                        biss_q  <= '0;
                        bpush_q <= '0;
                        if (pushed_q == count_q) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StFinish;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                StFinish: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Return-data path: output stage backed by a 2-entry in-order skid buffer
    always_ff @(posedge clkLOW or negedge rst) begin
        if (!rst) begin
            rd_pend_q  <= 1'b0;
            out_v_q    <= 1'b0;
            out_d_q    <= '0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            skid_cnt_q <= 2'd0;
        end else begin
            rd_pend_q <= memRd;
            if (!FULL) begin
                if (skid_cnt_q != 2'd0) begin
                    // Oldest skid word goes out first; a returning word queues behind it
                    out_v_q <= 1'b1;
                    out_d_q <= skid0_q;
                    skid0_q <= skid1_q;
                    if (rd_pend_q) begin
                        if (skid_cnt_q == 2'd1) skid0_q <= memData;
                        else                    skid1_q <= memData;
                    end else begin
                        skid_cnt_q <= skid_cnt_q - 2'd1;
                    end
                end else if (rd_pend_q) begin
                    out_v_q <= 1'b1;
                    out_d_q <= memData;
                end else begin
                    out_v_q <= 1'b0;
                end
            end else if (rd_pend_q) begin
                if (skid_cnt_q == 2'd0) skid0_q <= memData;
                else                    skid1_q <= memData;
                skid_cnt_q <= skid_cnt_q + 2'd1;
            end
        end
    end

`ifdef FEEDER_STATS_EN
    logic [15:0] stall_q;

    // Saturating count of busy cycles lost to pausing or FULL with data parked
    always_ff @(posedge clkLOW or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (state_q == StIdle && start) begin
            stall_q <= '0;
        end else if (busy && (state_q == StPause || (FULL && skid_cnt_q != 2'd0)) &&
                     stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stallCnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo32_feeder.sv
// Bench for fifo32_feeder: directed runs, scoreboard of expected addresses and
// FIFO words, monitor comparing on every memRd / validIN.
module tb_fifo32_feeder;

    logic        clkLOW = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] baseAddr = '0;
    logic [15:0] wordCount = '0;
    logic        memRd;
    logic [31:0] memAddr;
    logic [31:0] memData = '0;
    logic        AFULL = 1'b0;
    logic        FULL = 1'b0;
    logic        RSTcount = 1'b0;
    logic        validIN;
    logic [31:0] wrData;
    logic        busy;
    logic        done;
`ifdef FEEDER_STATS_EN
    logic [15:0] stallCnt;
`endif

    int          vec = 0;
    int          miss = 0;
    int          push_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];

    fifo32_feeder dut (
        .clkLOW   (clkLOW),
        .rst      (rst),
        .start    (start),
        .baseAddr (baseAddr),
        .wordCount(wordCount),
        .memRd    (memRd),
        .memAddr  (memAddr),
        .memData  (memData),
        .AFULL    (AFULL),
        .FULL     (FULL),
        .RSTcount (RSTcount),
        .validIN  (validIN),
        .wrData   (wrData),
        .busy     (busy),
        .done     (done)
`ifdef FEEDER_STATS_EN
        ,
        .stallCnt (stallCnt)
`endif
    );

    always #5 clkLOW = ~clkLOW;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Synchronous memory: data one cycle after the read strobe
    always @(posedge clkLOW) memData <= memRd ? mem_word(memAddr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clkLOW);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] cnt, input bit track);
        if (track) begin
            for (int i = 0; i < int'(cnt); i++) begin
                addr_q.push_back(base + 32'(i) * 32'd4);
                exp_q.push_back(mem_word(base + 32'(i) * 32'd4));
            end
        end
        baseAddr  = base;
        wordCount = cnt;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, {31'b0, done}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_memRd"}, {31'b0, memRd}, 32'd0);
        chk({tag, "_memAddr"}, memAddr, 32'd0);
        chk({tag, "_validIN"}, {31'b0, validIN}, 32'd0);
        chk({tag, "_wrData"}, wrData, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
    endtask

    // Monitor: compares every read address and every pushed word against the scoreboard
    initial begin
        forever begin
            @(negedge clkLOW);
            if (rst) begin
                if (memRd) begin
                    if (addr_q.size() == 0) begin
                        vec++;
                        miss++;
                        $display("FAIL sb_extra_read: got addr %h, expected no read", memAddr);
                    end else begin
                        chk("sb_memAddr", memAddr, addr_q.pop_front());
                    end
                end
                if (validIN) begin
                    push_cnt++;
                    if (exp_q.size() == 0) begin
                        vec++;
                        miss++;
                        $display("FAIL sb_extra_push: got word %h, expected no push", wrData);
                    end else begin
                        chk("sb_wrData", wrData, exp_q.pop_front());
                    end
                end
                if (FULL) chk("valid_while_full", {31'b0, validIN}, 32'd0);
                if (done) begin
                    done_cnt++;
                    chk("done_busy", {31'b0, busy}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m_rd, m_vld, m_done, m_busy;
        int n, r, v, extra, p0, dn;

        #2 rst = 1'b0;
        #1 chk_reset_outputs("rst");
        repeat (2) @(posedge clkLOW);
        #1 rst = 1'b1;
        tick(1);

        // T1: 4 words, no backpressure, cycle-exact timing
        m_rd   = 16'h003C;
        m_vld  = 16'h00F0;
        m_done = 16'h0100;
        m_busy = 16'h00FE;
        push_cnt = 0;
        do_start(32'h100, 16'd4, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clkLOW);
            chk("t1_memRd", {31'b0, memRd}, {31'b0, m_rd[c]});
            chk("t1_validIN", {31'b0, validIN}, {31'b0, m_vld[c]});
            chk("t1_done", {31'b0, done}, {31'b0, m_done[c]});
            chk("t1_busy", {31'b0, busy}, {31'b0, m_busy[c]});
            tick(1);
        end
        chk("t1_total", push_cnt, 4);

        // T2: 20 words, wait for RSTcount after the first 16
        push_cnt = 0;
        do_start(32'h2000, 16'd20, 1'b1);
        n = 0;
        while (push_cnt < 16 && n < 200) begin
            tick(1);
            n++;
        end
        chk("t2_burst", push_cnt, 16);
        tick(9);
        chk("t2_hold", push_cnt, 16);
        chk("t2_busy", {31'b0, busy}, 32'd1);
        RSTcount = 1'b1;
        tick(1);
        RSTcount = 1'b0;
        wait_done("t2_done", 100);
        chk("t2_total", push_cnt, 20);
        tick(1);

        // T3: AFULL after the 3rd read, held 5 cycles
        push_cnt = 0;
        do_start(32'h3000, 16'd8, 1'b1);
        r = 0;
        n = 0;
        while (r < 3 && n < 50) begin
            tick(1);
            n++;
            if (memRd) r++;
        end
        chk("t3_third_rd", r, 3);
        AFULL = 1'b1;
        extra = 0;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            if (i == 5) AFULL = 1'b0;
            @(negedge clkLOW);
            chk("t3_no_rd", {31'b0, memRd}, 32'd0);
            if (validIN) extra++;
        end
        chk("t3_extra", extra, 2);
        wait_done("t3_done", 100);
        chk("t3_total", push_cnt, 8);
        tick(1);

        // T4: FULL for 3 cycles with two reads in flight
        push_cnt = 0;
        do_start(32'h4000, 16'd6, 1'b1);
        r = 0;
        n = 0;
        while (r < 2 && n < 50) begin
            tick(1);
            n++;
            if (memRd) r++;
        end
        chk("t4_second_rd", r, 2);
        FULL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkLOW);
            chk("t4_stall", {31'b0, validIN}, 32'd0);
            tick(1);
        end
        FULL = 1'b0;
        chk("t4_none_during_full", push_cnt, 0);
        p0 = push_cnt;
        tick(4);
        chk("t4_drain", push_cnt - p0, 2);
        wait_done("t4_done", 100);
        chk("t4_total", push_cnt, 6);
        tick(1);

        // T5: zero-length run, then start while busy
        push_cnt = 0;
        do_start(32'h5000, 16'd0, 1'b1);
        @(negedge clkLOW);
        chk("t5_zero_done", {31'b0, done}, 32'd1);
        chk("t5_zero_busy", {31'b0, busy}, 32'd0);
        chk("t5_zero_rd", {31'b0, memRd}, 32'd0);
        tick(2);
        do_start(32'h5000, 16'd3, 1'b1);
        tick(1);
        chk("t5_busy", {31'b0, busy}, 32'd1);
        do_start(32'h9000, 16'd5, 1'b0);
        wait_done("t5_done", 100);
        tick(3);
        chk("t5_idle", {31'b0, busy}, 32'd0);
        chk("t5_total", push_cnt, 3);

        // T6: reset after 7 pushes, then a fresh run
        push_cnt = 0;
        dn = done_cnt;
        do_start(32'h6000, 16'd12, 1'b1);
        v = 0;
        n = 0;
        while (v < 7 && n < 100) begin
            tick(1);
            n++;
            if (validIN) v++;
        end
        chk("t6_seven", v, 7);
        @(posedge clkLOW);
        #3 rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        #1 chk_reset_outputs("t6");
        tick(3);
        chk("t6_no_done", done_cnt, dn);
        rst = 1'b1;
        tick(1);
        push_cnt = 0;
        do_start(32'h7000, 16'd3, 1'b1);
        wait_done("t6_done", 100);
        chk("t6_total", push_cnt, 3);
        tick(2);

        chk("sb_words_left", exp_q.size(), 0);
        chk("sb_addrs_left", addr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
